mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 581 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates one single-port frame memory between a pixel writer (grayscaler
// side) and a pixel reader (filter side). Ownership is granted in bursts of up
// to BURST_LEN grants. Every burst is followed by one IDLE bubble cycle. When
// both sides are eligible in IDLE, the side that did not own the last burst
// wins. The reader can never overtake the writer. A frame ends when the reader
// has consumed FRAME_PIXELS pixels. At that point frame_done pulses for one
// cycle and both pointers return to 0.
//
// Handshake: wr_gnt / rd_gnt are combinational and are asserted only in a
// cycle where the owner's request and eligibility hold in that same cycle.
// A grant means that the memory access happens on the next rising edge. The
// requester may drop its request at any time. A writer holding wr_req=1 must
// keep wr_data stable until it sees wr_gnt=1.
//
// Optional feature (macro ARB_WATCHDOG_EN): a reader-starvation watchdog that
// sets the sticky wdog_err flag after WDOG_CYCLES consecutive cycles of
// rd_req=1 without rd_gnt. When the macro is undefined, wdog_err is tied to 0.
//
// Ports
//   clk, rst     : clock; synchronous active-high reset
//   wr_req       : writer holds a valid pixel
//   wr_data[7:0] : writer pixel
//   wr_gnt       : writer pixel is written this cycle
//   rd_req       : reader requests the next pixel
//   rd_gnt       : read is issued to memory this cycle
//   rd_data[7:0] : read pixel, valid with rd_valid
//   rd_valid     : rd_gnt delayed by one cycle
//   mem_en       : memory port enable
//   mem_we       : memory write enable
//   mem_addr     : memory address, ADDR_W bits
//   mem_wdata    : memory write data, 8 bits
//   mem_rdata    : registered memory read data, one cycle after a read
//   frame_done   : one-cycle end-of-frame pulse
//   wdog_err     : sticky reader-starvation flag
//   fsm_state    : arbiter state for observation (0=IDLE, 1=WR_BURST, 2=RD_BURST)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int FRAME_PIXELS = 65536,
    parameter int BURST_LEN    = 8,
    parameter int WDOG_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [7:0]        wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    output logic              rd_gnt,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              frame_done,
    output logic              wdog_err,
    output logic [1:0]        fsm_state
);

    // Elaboration-time parameter legality.
    if (BURST_LEN < 1) begin : g_bad_burst
        $error("mem_arbiter: BURST_LEN must be at least 1");
    end
    if (FRAME_PIXELS < 1 || FRAME_PIXELS > (1 << ADDR_W)) begin : g_bad_frame
        $error("mem_arbiter: FRAME_PIXELS must be in 1..2^ADDR_W");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("mem_arbiter: WDOG_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    // Pointers carry one extra bit so that "frame full" (== FRAME_PIXELS) is
    // representable even when FRAME_PIXELS = 2^ADDR_W.
    localparam int                PTR_W     = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  FRAME_END = PTR_W'(FRAME_PIXELS);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    // The burst counter holds the number of grants already given in the
    // current burst, 0..BURST_LEN-1.
    localparam int                CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   burst_cnt;
    logic               last_owner_wr;   // 1: writer owned the last burst
    logic               rd_valid_q;

    logic               wr_elig;
    logic               rd_elig;
    logic               frame_hit;

    // ------------------------------------------------------------------
    // Eligibility and grants (combinational)
    // ------------------------------------------------------------------
    assign wr_elig   = wr_req && (wr_ptr < FRAME_END);
    assign rd_elig   = rd_req && (rd_ptr < wr_ptr);
    assign frame_hit = (rd_ptr == FRAME_END);

    // Grants are gated by rst so that a burst interrupted by reset issues
    // nothing in the reset cycle.
    assign wr_gnt = !rst && (state == WR_BURST) && wr_elig;
    assign rd_gnt = !rst && (state == RD_BURST) && rd_elig;

    assign mem_en    = wr_gnt || rd_gnt;
    assign mem_we    = wr_gnt;
    assign mem_addr  = wr_gnt ? wr_ptr[ADDR_W-1:0] :
                       rd_gnt ? rd_ptr[ADDR_W-1:0] : '0;
    assign mem_wdata = wr_gnt ? wr_data : 8'd0;

    // A read granted just before reset must not show up during reset.
    assign rd_valid   = rd_valid_q && !rst;
    assign rd_data    = rd_valid ? mem_rdata : 8'd0;
    assign frame_done = frame_hit && !rst;
    assign fsm_state  = rst ? IDLE : state;

    // ------------------------------------------------------------------
    // Arbiter FSM and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            burst_cnt     <= '0;
            last_owner_wr <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            rd_valid_q <= rd_gnt;

            if (frame_hit) begin
                // End of frame: both pointers are at FRAME_PIXELS, so neither
                // side is eligible and no grant happens in this cycle.
                state     <= IDLE;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                burst_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        burst_cnt <= '0;
                        // Writer wins if it is alone, or if both are eligible
                        // and the reader owned the last burst.
                        if (wr_elig && (!rd_elig || !last_owner_wr)) begin
                            state         <= WR_BURST;
                            last_owner_wr <= 1'b1;
                        end else if (rd_elig) begin
                            state         <= RD_BURST;
                            last_owner_wr <= 1'b0;
                        end
                    end

                    WR_BURST: begin
                        if (wr_elig) begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                            if (burst_cnt == BURST_LAST) begin
                                state     <= IDLE;
                                burst_cnt <= '0;
                            end else begin
                                burst_cnt <= burst_cnt + CNT_ONE;
                            end
                        end else begin
                            // Owner dropped out: this cycle had no grant.
                            state     <= IDLE;
                            burst_cnt <= '0;
                        end
                    end

                    RD_BURST: begin
                        if (rd_elig) begin
                            rd_ptr <= rd_ptr + PTR_ONE;
                            if (burst_cnt == BURST_LAST) begin
                                state     <= IDLE;
                                burst_cnt <= '0;
                            end else begin
                                burst_cnt <= burst_cnt + CNT_ONE;
                            end
                        end else begin
                            state     <= IDLE;
                            burst_cnt <= '0;
                        end
                    end

                    default: begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Reader-starvation watchdog
    // ------------------------------------------------------------------
`ifdef ARB_WATCHDOG_EN
    localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_PRE  = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
        end else if (rd_req && !rd_gnt) begin
            // Saturate at WDOG_CYCLES; the flag sets on the same edge the
            // counter reaches it.
            if (wdog_cnt != WDOG_MAX) begin
                wdog_cnt <= wdog_cnt + WDOG_ONE;
            end
            if (wdog_cnt == WDOG_PRE) begin
                wdog_q <= 1'b1;
            end
        end else begin
            wdog_cnt <= '0;
        end
    end

    assign wdog_err = wdog_q && !rst;
`else
    assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter with FRAME_PIXELS=16, BURST_LEN=4 and WDOG_CYCLES=20.
// A behavioural memory answers reads one cycle after they are issued. A
// background writer process holds a pixel on wr_data until it is granted.
// A negedge scoreboard tracks the frame as pixel counts, and a pixel array
// records what was written. It checks every grant address, every read-back
// value, the frame_done timing and the rule that no read is issued before
// its pixel is written. Scenario tasks then check the burst and idle-bubble
// timing derived from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 4;
  localparam int FP     = 16;
  localparam int BL     = 4;
  localparam int WD     = 20;

  logic              clk;
  logic              rst;
  logic              wr_req;
  logic [7:0]        wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic              rd_gnt;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              frame_done;
  logic              wdog_err;
  logic [1:0]        fsm_state;

  int checks   = 0;
  int failures = 0;

  // writer driver controls
  bit wr_en     = 1'b0;
  int wr_limit  = 0;
  bit rand_data = 1'b0;
  int pix_sent  = 0;

  mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .FRAME_PIXELS(FP),
    .BURST_LEN   (BL),
    .WDOG_CYCLES (WD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_gnt    (rd_gnt),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .frame_done(frame_done),
    .wdog_err  (wdog_err),
    .fsm_state (fsm_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory model ----------------
  logic [7:0] mem_model [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  // ---------------- writer driver ----------------
  function automatic logic [7:0] pix_val(input int i);
    if (rand_data) return 8'($urandom_range(0, 255));
    return 8'(i);
  endfunction

  initial begin
    bit took;
    bit was_rst;
    wr_req  = 1'b0;
    wr_data = 8'd0;
    forever begin
      @(negedge clk);
      took    = (wr_gnt === 1'b1);
      was_rst = rst;
      @(posedge clk);
      #2;
      if (was_rst) begin
        pix_sent = 0;
        wr_data  = pix_val(0);
      end else if (took) begin
        pix_sent++;
        wr_data = pix_val(pix_sent);
      end
      wr_req = wr_en && (pix_sent < wr_limit);
    end
  end

  // ---------------- scoreboard ----------------
  int         model_wr = 0;
  int         model_rd = 0;
  logic [7:0] px [0:FP-1];
  logic [7:0] exp_q[$];
  logic [7:0] exp_d;

  always @(negedge clk) begin
    if (rst) begin
      model_wr = 0;
      model_rd = 0;
      exp_q.delete();
    end else begin
      checks++;
      if (mem_en !== (wr_gnt | rd_gnt) || mem_we !== wr_gnt || (wr_gnt && rd_gnt)) begin
        failures++;
        $display("FAIL mon_mem_ctrl: mem_en=%b mem_we=%b wr_gnt=%b rd_gnt=%b", mem_en, mem_we, wr_gnt, rd_gnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
        exp_d = exp_q.pop_front();
        if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
          failures++;
          $display("FAIL mon_rd_data: rd_valid=%b rd_data=%0h expected valid=1 data=%0h", rd_valid, rd_data, exp_d);
        end
      end else if (rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL mon_rd_valid: rd_valid=%b expected 0", rd_valid);
      end
      checks++;
      if (frame_done !== (model_rd == FP)) begin
        failures++;
        $display("FAIL mon_frame_done: frame_done=%b expected %b (reads=%0d)", frame_done, (model_rd == FP), model_rd);
      end
      if (wr_gnt === 1'b1) begin
        checks++;
        if (model_wr >= FP || mem_addr !== ADDR_W'(model_wr) || mem_wdata !== wr_data) begin
          failures++;
          $display("FAIL mon_write: addr=%0d wdata=%0h expected addr=%0d wdata=%0h (written=%0d)", mem_addr, mem_wdata, model_wr, wr_data, model_wr);
        end
        if (model_wr < FP) px[model_wr] = wr_data;
        model_wr++;
      end
      if (rd_gnt === 1'b1) begin
        checks++;
        if (model_rd >= model_wr || mem_addr !== ADDR_W'(model_rd)) begin
          failures++;
          $display("FAIL mon_read: addr=%0d expected addr=%0d (written=%0d)", mem_addr, model_rd, model_wr);
        end
        if (model_rd < FP) exp_q.push_back(px[model_rd]);
        model_rd++;
      end
      if (frame_done === 1'b1) begin
        model_wr = 0;
        model_rd = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given stimulus set up. Returns at posedge+1 in the first
  // cycle after reset, in which the arbiter is idle.
  task automatic start(input bit w, input int lim, input bit r, input bit rnd);
    rst       = 1'b1;
    wr_en     = w;
    wr_limit  = lim;
    rd_req    = r;
    rand_data = rnd;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    wr_en     = 1'b1;
    wr_limit  = 1000;
    rd_req    = 1'b1;
    rand_data = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({wr_gnt, rd_gnt, rd_valid, mem_en, mem_we, frame_done, wdog_err} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl: gnt/valid/en/we/fd/wdog=%b expected 0", {wr_gnt, rd_gnt, rd_valid, mem_en, mem_we, frame_done, wdog_err});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== 8'd0 || rd_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_data: addr=%0h wdata=%0h rd_data=%0h expected 0", mem_addr, mem_wdata, rd_data);
    end
    checks++;
    if (fsm_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: state=%0d expected 0", fsm_state);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fsm_state !== 2'd0 || wr_gnt !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_idle: state=%0d wr_gnt=%b expected 0/0", fsm_state, wr_gnt);
    end
    @(negedge clk);
    checks++;
    if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_writer_first: wr_gnt=%b rd_gnt=%b addr=%0d expected 1/0/0", wr_gnt, rd_gnt, mem_addr);
    end
  endtask

  task automatic test_write_bursts();
    int n;
    n = 0;
    start(1'b1, FP, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wr_gnt === 1'b1) begin
        checks++;
        if (k != 1 + n + n / BL || mem_addr !== ADDR_W'(n) || mem_wdata !== 8'(n)) begin
          failures++;
          $display("FAIL wr_burst_timing: grant %0d at cycle %0d addr=%0d data=%0h expected cycle %0d addr=%0d data=%0h", n, k, mem_addr, mem_wdata, 1 + n + n / BL, n, n);
        end
        n++;
      end
    end
    checks++;
    if (n != FP) begin
      failures++;
      $display("FAIL wr_burst_count: grants=%0d expected %0d", n, FP);
    end
  endtask

  // Continues from test_write_bursts: the frame is fully written.
  task automatic test_read_frame();
    int n;
    int v;
    int fd_n;
    int fd_k;
    int last_k;
    int gk [0:FP-1];
    bit found;
    n = 0; v = 0; fd_n = 0; fd_k = -1; last_k = -1;
    tick();
    rd_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        checks++;
        if (v >= n || k != gk[v] + 1 || rd_data !== 8'(v)) begin
          failures++;
          $display("FAIL rd_valid_latency: valid %0d at cycle %0d data=%0h expected data=%0h one cycle after grant", v, k, rd_data, v);
        end
        v++;
      end
      if (rd_gnt === 1'b1) begin
        checks++;
        if (k != 1 + n + n / BL || mem_addr !== ADDR_W'(n)) begin
          failures++;
          $display("FAIL rd_burst_timing: grant %0d at cycle %0d addr=%0d expected cycle %0d addr=%0d", n, k, mem_addr, 1 + n + n / BL, n);
        end
        if (n < FP) gk[n] = k;
        last_k = k;
        n++;
      end
      if (frame_done === 1'b1) begin
        fd_n++;
        fd_k = k;
      end
    end
    checks++;
    if (n != FP || v != FP) begin
      failures++;
      $display("FAIL rd_frame_count: grants=%0d valids=%0d expected %0d", n, v, FP);
    end
    checks++;
    if (fd_n != 1 || fd_k != last_k + 1) begin
      failures++;
      $display("FAIL frame_done_pulse: pulses=%0d at cycle %0d expected 1 at cycle %0d", fd_n, fd_k, last_k + 1);
    end
    // The pointers are cleared: new writes start at address 0.
    tick();
    rd_req   = 1'b0;
    wr_limit = FP + 4;
    found    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wr_gnt === 1'b1 && !found) begin
        found = 1'b1;
        checks++;
        if (mem_addr !== '0) begin
          failures++;
          $display("FAIL new_frame_addr: addr=%0d expected 0", mem_addr);
        end
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL new_frame_grant: no write grant within 10 cycles expected one");
    end
  endtask

  task automatic test_concurrent();
    int  blen[$];
    bit  bown[$];
    bit  prev_g;
    bit  prev_own;
    bit  done;
    int  reads;
    prev_g = 1'b0; prev_own = 1'b0; done = 1'b0; reads = 0;
    start(1'b1, 100000, 1'b1, 1'b1);
    for (int k = 0; k < 120 && !done; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        done = 1'b1;
        checks++;
        if (reads != FP) begin
          failures++;
          $display("FAIL conc_frame_done: reads=%0d expected %0d", reads, FP);
        end
      end else if (wr_gnt === 1'b1 || rd_gnt === 1'b1) begin
        if (rd_gnt === 1'b1) reads++;
        if (!prev_g) begin
          checks++;
          if (wr_gnt !== ((bown.size() % 2) == 0)) begin
            failures++;
            $display("FAIL conc_alternate: burst %0d owner writer=%b expected %b", bown.size(), wr_gnt, ((bown.size() % 2) == 0));
          end
          bown.push_back(wr_gnt);
          blen.push_back(1);
        end else begin
          checks++;
          if (wr_gnt !== prev_own) begin
            failures++;
            $display("FAIL conc_bubble: owner changed without idle cycle at cycle %0d", k);
          end
          blen[blen.size() - 1] = blen[blen.size() - 1] + 1;
        end
        prev_g   = 1'b1;
        prev_own = wr_gnt;
      end else begin
        prev_g = 1'b0;
      end
    end
    checks++;
    if (!done || blen.size() != 2 * FP / BL) begin
      failures++;
      $display("FAIL conc_bursts: frame_done=%b bursts=%0d expected 1/%0d", done, blen.size(), 2 * FP / BL);
    end
    foreach (blen[i]) begin
      checks++;
      if (blen[i] != BL) begin
        failures++;
        $display("FAIL conc_burst_len: burst %0d len=%0d expected %0d", i, blen[i], BL);
      end
    end
  endtask

  task automatic test_reader_stall();
    int n;
    int g1;
    int g2;
    n = 0; g1 = -1; g2 = -1;
    start(1'b1, 2, 1'b0, 1'b1);
    repeat (10) tick();
    rd_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rd_gnt === 1'b1) begin
        n++;
        if (n == 1) g1 = k;
        if (n == 2) g2 = k;
      end
      if (g2 >= 0 && k == g2 + 1) begin
        checks++;
        if (fsm_state !== 2'd2 || rd_gnt !== 1'b0) begin
          failures++;
          $display("FAIL stall_ineligible: state=%0d rd_gnt=%b expected 2/0", fsm_state, rd_gnt);
        end
      end
      if (g2 >= 0 && k == g2 + 2) begin
        checks++;
        if (fsm_state !== 2'd0) begin
          failures++;
          $display("FAIL stall_to_idle: state=%0d expected 0", fsm_state);
        end
      end
    end
    checks++;
    if (n != 2 || g2 != g1 + 1 || fsm_state !== 2'd0) begin
      failures++;
      $display("FAIL stall_reads: reads=%0d gap=%0d state=%0d expected 2/1/0", n, g2 - g1, fsm_state);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_rst_mid_burst();
    bit found;
    found = 1'b0;
    start(1'b1, 100000, 1'b0, 1'b0);
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (wr_gnt === 1'b1 && mem_addr == ADDR_W'(5)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_mid_setup: no write to address 5 within 30 cycles expected one");
    end
    tick();
    rst = 1'b1;          // the arbiter is in WR_BURST with wr_ptr=6
    @(negedge clk);
    checks++;
    if ({wr_gnt, rd_gnt, rd_valid, mem_en, mem_we, frame_done, wdog_err} !== 7'd0 ||
        mem_addr !== '0 || mem_wdata !== 8'd0 || rd_data !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs: ctrl=%b addr=%0d wdata=%0h rd_data=%0h expected all 0",
               {wr_gnt, rd_gnt, rd_valid, mem_en, mem_we, frame_done, wdog_err}, mem_addr, mem_wdata, rd_data);
    end
    tick();
    rst   = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (wr_gnt === 1'b1) begin
        found = 1'b1;
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 8'd0) begin
          failures++;
          $display("FAIL rst_mid_restart: addr=%0d wdata=%0h expected 0/0", mem_addr, mem_wdata);
        end
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_mid_regrant: no write grant within 10 cycles expected one");
    end
    // Reset right after a read grant hides the pending rd_valid.
    tick();
    rd_req = 1'b1;
    found  = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (rd_gnt === 1'b1) found = 1'b1;
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!found || rd_valid !== 1'b0 || rd_data !== 8'd0) begin
      failures++;
      $display("FAIL rst_rd_valid: read_seen=%b rd_valid=%b rd_data=%0h expected 1/0/0", found, rd_valid, rd_data);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_rd_valid_after: rd_valid=%b expected 0", rd_valid);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_random();
    int fd_n;
    fd_n = 0;
    start(1'b1, 100000, 1'b0, 1'b1);
    for (int k = 0; k < 800; k++) begin
      wr_en  = ($urandom_range(0, 9) < 7);
      rd_req = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (frame_done === 1'b1) fd_n++;
      tick();
    end
    checks++;
    if (fd_n < 1) begin
      failures++;
      $display("FAIL random_frames: frames=%0d expected at least 1", fd_n);
    end
    rd_req = 1'b0;
    wr_en  = 1'b0;
  endtask

  task automatic test_watchdog();
    bit exp_err;
    start(1'b0, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
`ifdef ARB_WATCHDOG_EN
      exp_err = (k >= WD + 1);
`else
      exp_err = 1'b0;
`endif
      checks++;
      if (wdog_err !== exp_err) begin
        failures++;
        $display("FAIL wdog_rise: starved cycle %0d wdog_err=%b expected %b", k, wdog_err, exp_err);
      end
    end
    tick();
    rd_req = 1'b0;
    repeat (5) tick();
    @(negedge clk);
`ifdef ARB_WATCHDOG_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    checks++;
    if (wdog_err !== exp_err) begin
      failures++;
      $display("FAIL wdog_sticky: wdog_err=%b expected %b", wdog_err, exp_err);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wdog_err !== 1'b0) begin
      failures++;
      $display("FAIL wdog_reset: wdog_err=%b expected 0", wdog_err);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wdog_err !== 1'b0) begin
      failures++;
      $display("FAIL wdog_cleared: wdog_err=%b expected 0", wdog_err);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    rst    = 1'b1;
    rd_req = 1'b0;
    test_reset();
    test_write_bursts();
    test_read_frame();
    test_concurrent();
    test_reader_stall();
    test_rst_mid_burst();
    test_random();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout: simulation did not finish within 500000 time units");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
